// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, round constants and RotWord,
// used by both the key schedule and the cipher datapath.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_NK = 4;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_EMIT
   } state_e;

   // Round constants for rounds 1..10, stored MSB byte only
   localparam logic [10:1][7:0] RCON = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
      8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
      return v;
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Row 0 of the table sits in the top bits, so entry x lives at (255-x)*8
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key scheduler: expands forward to round 10, then streams
// round keys 10..0, regenerating each one backward from the previous.
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_last
);

   state_e     state_q;
   block_t     key_q;
   logic [3:0] cnt_q;
   logic       busy_q;
   logic       valid_q;

   word_t  w0, w1, w2, w3, w3Back;
   word_t  sboxIn, sboxOut, tWord;
   block_t fwdKey_d, bwdKey_d;

   // One S-box group serves both directions; only its input word and the
   // round constant index change with the state.
   always_comb begin
      w0       = key_q[127:96];
      w1       = key_q[95:64];
      w2       = key_q[63:32];
      w3       = key_q[31:0];
      w3Back   = w3 ^ w2;
      sboxIn   = (state_q == ST_EMIT) ? rot_word(w3Back) : rot_word(w3);
      tWord    = sboxOut ^ {rcon((state_q == ST_EMIT) ? cnt_q : cnt_q + 4'd1), 24'h000000};
      fwdKey_d[127:96] = w0 ^ tWord;
      fwdKey_d[95:64]  = w1 ^ fwdKey_d[127:96];
      fwdKey_d[63:32]  = w2 ^ fwdKey_d[95:64];
      fwdKey_d[31:0]   = w3 ^ fwdKey_d[63:32];
      bwdKey_d = {w0 ^ tWord, w1 ^ w0, w2 ^ w1, w3Back};
   end

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (sboxIn[8*i +: 8]),
         .out_o (sboxOut[8*i +: 8])
      );
   end

   // The counter doubles as rk_idx while emitting; returning to idle wipes
   // all key material.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  key_q   <= key_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               key_q <= fwdKey_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(AES_NR - 1)) begin
                  state_q <= ST_EMIT;
                  valid_q <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (rk_ready) begin
                  if (cnt_q != 4'd0) begin
                     key_q <= bwdKey_d;
                     cnt_q <= cnt_q - 4'd1;
                  end else begin
                     key_q   <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               key_q   <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign rk_valid = valid_q;
   assign rk_out   = valid_q ? key_q : '0;
   assign rk_idx   = valid_q ? cnt_q : 4'd0;
   assign rk_last  = valid_q && (cnt_q == 4'd0);

endmodule
